// File: rtl/idma_obi_write_mux_pkg.sv
// Local OBI write request/response types and the index-width helper shared by
// the write mux and its testbench.
package idma_obi_write_mux_pkg;

  localparam int unsigned ObiAddrWidth = 32;
  localparam int unsigned ObiDataWidth = 32;
  localparam int unsigned ObiIdWidth   = 2;

  typedef struct packed {
    logic [ObiAddrWidth-1:0]   addr;
    logic                      we;
    logic [ObiDataWidth/8-1:0] be;
    logic [ObiDataWidth-1:0]   wdata;
    logic [ObiIdWidth-1:0]     aid;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
    logic        rready;
  } obi_write_req_t;

  typedef struct packed {
    logic [ObiDataWidth-1:0] rdata;
    logic [ObiIdWidth-1:0]   rid;
    logic                    err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } obi_write_rsp_t;

  // Width of an index into n items; a single item still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/idma_obi_write_mux_fifo.sv
// Registered FIFO with fill count; fall-through mode forwards data_i while empty.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [ADDR_DEPTH-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [ADDR_DEPTH:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  function automatic logic [ADDR_DEPTH-1:0] next_ptr(input logic [ADDR_DEPTH-1:0] p);
    return (p == ADDR_DEPTH'(DEPTH - 1)) ? '0 : p + ADDR_DEPTH'(1);
  endfunction

  assign usage_o = cnt_q[ADDR_DEPTH-1:0];
  assign full_o  = (cnt_q == (ADDR_DEPTH+1)'(DEPTH));
  assign empty_o = (cnt_q == '0) & ~(FALL_THROUGH & push_i);

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    mem_d  = mem_q;
    data_o = mem_q[rptr_q];
    if (push_i && !full_o) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = next_ptr(wptr_q);
      cnt_d         = cnt_q + 1'b1;
    end
    if (pop_i && !empty_o) begin
      rptr_d = next_ptr(rptr_q);
      cnt_d  = (push_i && !full_o) ? cnt_q : cnt_q - 1'b1;
    end
    // Bypassed word consumed in the same cycle: nothing is stored.
    if (FALL_THROUGH && (cnt_q == '0) && push_i) begin
      data_o = data_i;
      if (pop_i) begin
        cnt_d  = cnt_q;
        rptr_d = rptr_q;
        wptr_d = wptr_q;
      end
    end
    if (flush_i) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      mem_q  <= '{default: '0};
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      mem_q  <= mem_d;
    end
  end

endmodule

// File: rtl/idma_obi_write_mux.sv
// Shares one OBI write manager port among NumPorts backends: round-robin A-channel
// arbitration with grant lock, in-order R routing via a FIFO of accepted indices.
module idma_obi_write_mux
  import idma_obi_write_mux_pkg::*;
#(
  parameter int unsigned NumPorts       = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter type         write_req_t    = obi_write_req_t,
  parameter type         write_rsp_t    = obi_write_rsp_t,
  parameter int unsigned IdxWidth       = idx_width(NumPorts)
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  write_req_t slv_req_i [NumPorts],
  output write_rsp_t slv_rsp_o [NumPorts],
  output write_req_t mgr_req_o,
  input  write_rsp_t mgr_rsp_i,
  output logic       busy_o
);

  localparam int unsigned CntWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef logic [IdxWidth-1:0] idx_t;

  idx_t                rr_q, rr_d, locked_idx_q, locked_idx_d;
  idx_t                sel, head, cand;
  logic                lock_q, lock_d, found;
  logic                fifo_full, fifo_empty;
  logic                req_gated, rready_mux, accept, pop;
  logic [CntWidth-1:0] usage;
  logic [CntWidth:0]   count;

  always_comb begin
    sel   = rr_q;
    cand  = '0;
    found = 1'b0;
    if (lock_q) begin
      sel = locked_idx_q;
    end else begin
      for (int unsigned i = 0; i < NumPorts; i++) begin
        cand = idx_t'((32'(rr_q) + i) % NumPorts);
        if (!found && slv_req_i[cand].req) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  // Full gating uses the registered fill level so gnt never depends on rvalid.
  assign req_gated  = slv_req_i[sel].req & ~fifo_full;
  assign rready_mux = fifo_empty ? 1'b1 : slv_req_i[head].rready;
  assign accept     = rst_ni & req_gated & mgr_rsp_i.gnt;
  assign pop        = rst_ni & mgr_rsp_i.rvalid & rready_mux & ~fifo_empty;

  always_comb begin
    mgr_req_o = '0;
    busy_o    = 1'b0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      slv_rsp_o[p] = '0;
    end
    if (rst_ni) begin
      mgr_req_o.a        = slv_req_i[sel].a;
      mgr_req_o.req      = req_gated;
      mgr_req_o.rready   = rready_mux;
      slv_rsp_o[sel].gnt = mgr_rsp_i.gnt & req_gated;
      if (!fifo_empty) begin
        slv_rsp_o[head].rvalid = mgr_rsp_i.rvalid;
        slv_rsp_o[head].r      = mgr_rsp_i.r;
      end
      busy_o = ~fifo_empty;
    end
  end

  always_comb begin
    rr_d         = rr_q;
    lock_d       = lock_q;
    locked_idx_d = locked_idx_q;
    if (accept) begin
      lock_d = 1'b0;
      rr_d   = (sel == idx_t'(NumPorts - 1)) ? '0 : sel + idx_t'(1);
    end else if (rst_ni && req_gated) begin
      lock_d       = 1'b1;
      locked_idx_d = sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q         <= '0;
      lock_q       <= 1'b0;
      locked_idx_q <= '0;
    end else begin
      rr_q         <= rr_d;
      lock_q       <= lock_d;
      locked_idx_q <= locked_idx_d;
    end
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (IdxWidth),
    .DEPTH        (MaxOutstanding)
  ) i_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (usage),
    .data_i  (sel),
    .push_i  (accept),
    .data_o  (head),
    .pop_i   (pop)
  );

  assign count = fifo_full ? (CntWidth+1)'(MaxOutstanding) : {1'b0, usage};

  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mgr_req_o.req && !mgr_rsp_i.gnt) |=> (mgr_req_o.req && $stable(mgr_req_o.a)));

  a_count_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (count <= (CntWidth+1)'(MaxOutstanding)) && !(fifo_full && accept));

  a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    mgr_rsp_i.rvalid |-> !fifo_empty);

endmodule

// File: tb/tb_idma_obi_write_mux.sv
// Directed testbench for idma_obi_write_mux with NumPorts=2, MaxOutstanding=4.
module tb_idma_obi_write_mux;
  import idma_obi_write_mux_pkg::*;

  localparam int unsigned NP = 2;
  localparam int unsigned MO = 4;

  logic           clk, rst_n;
  obi_write_req_t slv_req [NP];
  obi_write_rsp_t slv_rsp [NP];
  obi_write_req_t mgr_req;
  obi_write_rsp_t mgr_rsp;
  logic           busy;
  int             checks, errors;

  idma_obi_write_mux #(
    .NumPorts       (NP),
    .MaxOutstanding (MO)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .slv_req_i (slv_req),
    .slv_rsp_o (slv_rsp),
    .mgr_req_o (mgr_req),
    .mgr_rsp_i (mgr_rsp),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obi_a_chan_t mk_a(input int p, input int n);
    obi_a_chan_t a;
    a.addr  = 32'h1000_0000 + 32'(p) * 32'h1_0000 + 32'(n) * 4;
    a.we    = 1'b1;
    a.be    = 4'hF;
    a.wdata = 32'hD000_0000 + 32'(p) * 256 + 32'(n);
    a.aid   = 2'(p);
    return a;
  endfunction

  task automatic drive(input logic r0, input logic r1, input int n0, input int n1,
                       input logic g, input logic rv, input int rd);
    slv_req[0].req    = r0;
    slv_req[1].req    = r1;
    slv_req[0].a      = mk_a(0, n0);
    slv_req[1].a      = mk_a(1, n1);
    mgr_rsp.gnt       = g;
    mgr_rsp.rvalid    = rv;
    mgr_rsp.r.rdata   = 32'hBEEF_0000 + 32'(rd);
    mgr_rsp.r.rid     = 2'(rd);
    mgr_rsp.r.err     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    slv_req[0] = '0;
    slv_req[1] = '0;
    mgr_rsp    = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (mgr_req !== '0) begin errors++; $display("FAIL rst_mgr_req got %h exp 0", mgr_req); end
    @(negedge clk);
    rst_n = 1'b1;
    slv_req[0].rready = 1'b1;
    slv_req[1].rready = 1'b1;
    @(negedge clk); #1;
    checks++; if (mgr_req.req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", mgr_req.req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if ({slv_rsp[1].gnt, slv_rsp[0].gnt} !== 2'b00) begin errors++;
      $display("FAIL rst_gnt got %b exp 00", {slv_rsp[1].gnt, slv_rsp[0].gnt}); end
    checks++; if (mgr_req.rready !== 1'b1) begin errors++; $display("FAIL rst_rready got %b exp 1", mgr_req.rready); end
  endtask

  task automatic test_round_robin();
    int         exp_sel [4] = '{0, 1, 0, 1};
    int         h;
    logic [1:0] eg, ev;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(c < 4, c < 4, c, c, c < 4, c >= 2, c);
      #1;
      if (c < 4) begin
        eg = (exp_sel[c] == 0) ? 2'b01 : 2'b10;
        checks++; if ({slv_rsp[1].gnt, slv_rsp[0].gnt} !== eg) begin errors++;
          $display("FAIL rr_gnt c=%0d got %b exp %b", c, {slv_rsp[1].gnt, slv_rsp[0].gnt}, eg); end
        checks++; if (mgr_req.a !== mk_a(exp_sel[c], c)) begin errors++;
          $display("FAIL rr_a c=%0d got %h exp %h", c, mgr_req.a, mk_a(exp_sel[c], c)); end
      end
      if (c >= 2) begin
        h  = exp_sel[c-2];
        ev = (h == 0) ? 2'b01 : 2'b10;
        checks++; if ({slv_rsp[1].rvalid, slv_rsp[0].rvalid} !== ev) begin errors++;
          $display("FAIL rr_rvalid c=%0d got %b exp %b", c, {slv_rsp[1].rvalid, slv_rsp[0].rvalid}, ev); end
        checks++; if (slv_rsp[h].r.rdata !== 32'hBEEF_0000 + 32'(c)) begin errors++;
          $display("FAIL rr_rdata c=%0d got %h exp %h", c, slv_rsp[h].r.rdata, 32'hBEEF_0000 + 32'(c)); end
        checks++; if (slv_rsp[1-h].r !== '0) begin errors++;
          $display("FAIL rr_r_other c=%0d got %h exp 0", c, slv_rsp[1-h].r); end
      end
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_drained got %b exp 0", busy); end
  endtask

  task automatic test_lock();
    @(negedge clk); drive(0, 1, 0, 10, 0, 0, 0); #1;
    checks++; if (mgr_req.req !== 1'b1 || mgr_req.a !== mk_a(1, 10)) begin errors++;
      $display("FAIL lock_first got req=%b a=%h exp req=1 a=%h", mgr_req.req, mgr_req.a, mk_a(1, 10)); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); drive(1, 1, 11, 10, 0, 0, 0); #1;
      checks++; if (mgr_req.a !== mk_a(1, 10)) begin errors++;
        $display("FAIL lock_hold c=%0d got %h exp %h", c, mgr_req.a, mk_a(1, 10)); end
      checks++; if ({slv_rsp[1].gnt, slv_rsp[0].gnt} !== 2'b00) begin errors++;
        $display("FAIL lock_nognt c=%0d got %b exp 00", c, {slv_rsp[1].gnt, slv_rsp[0].gnt}); end
    end
    @(negedge clk); drive(1, 1, 11, 10, 1, 0, 0); #1;
    checks++; if ({slv_rsp[1].gnt, slv_rsp[0].gnt} !== 2'b10 || mgr_req.a !== mk_a(1, 10)) begin errors++;
      $display("FAIL lock_gnt1 got gnt=%b a=%h exp gnt=10 a=%h", {slv_rsp[1].gnt, slv_rsp[0].gnt}, mgr_req.a, mk_a(1, 10)); end
    @(negedge clk); drive(1, 0, 11, 0, 1, 0, 0); #1;
    checks++; if ({slv_rsp[1].gnt, slv_rsp[0].gnt} !== 2'b01 || mgr_req.a !== mk_a(0, 11)) begin errors++;
      $display("FAIL lock_next0 got gnt=%b a=%h exp gnt=01 a=%h", {slv_rsp[1].gnt, slv_rsp[0].gnt}, mgr_req.a, mk_a(0, 11)); end
    @(negedge clk); drive(0, 0, 0, 0, 0, 1, 1); #1;
    checks++; if ({slv_rsp[1].rvalid, slv_rsp[0].rvalid} !== 2'b10) begin errors++;
      $display("FAIL lock_r1 got %b exp 10", {slv_rsp[1].rvalid, slv_rsp[0].rvalid}); end
    @(negedge clk); drive(0, 0, 0, 0, 0, 1, 2); #1;
    checks++; if ({slv_rsp[1].rvalid, slv_rsp[0].rvalid} !== 2'b01) begin errors++;
      $display("FAIL lock_r0 got %b exp 01", {slv_rsp[1].rvalid, slv_rsp[0].rvalid}); end
  endtask

  task automatic test_full();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); drive(1, 0, 20 + c, 0, 1, 0, 0); #1;
      checks++; if ({slv_rsp[1].gnt, slv_rsp[0].gnt} !== 2'b01) begin errors++;
        $display("FAIL full_fill c=%0d got %b exp 01", c, {slv_rsp[1].gnt, slv_rsp[0].gnt}); end
    end
    // count 4: pop and pending request in the same cycle; no grant yet
    @(negedge clk); drive(0, 1, 0, 30, 1, 1, 3); #1;
    checks++; if (mgr_req.req !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("FAIL full_gate got req=%b busy=%b exp req=0 busy=1", mgr_req.req, busy); end
    checks++; if ({slv_rsp[1].gnt, slv_rsp[0].gnt} !== 2'b00) begin errors++;
      $display("FAIL full_nognt got %b exp 00", {slv_rsp[1].gnt, slv_rsp[0].gnt}); end
    checks++; if ({slv_rsp[1].rvalid, slv_rsp[0].rvalid} !== 2'b01) begin errors++;
      $display("FAIL full_pop got %b exp 01", {slv_rsp[1].rvalid, slv_rsp[0].rvalid}); end
    @(negedge clk); drive(0, 1, 0, 30, 1, 0, 0); #1;
    checks++; if (mgr_req.req !== 1'b1 || {slv_rsp[1].gnt, slv_rsp[0].gnt} !== 2'b10) begin errors++;
      $display("FAIL full_resume got req=%b gnt=%b exp req=1 gnt=10", mgr_req.req, {slv_rsp[1].gnt, slv_rsp[0].gnt}); end
    @(negedge clk); drive(0, 1, 0, 31, 1, 0, 0); #1;
    checks++; if (mgr_req.req !== 1'b0 || {slv_rsp[1].gnt, slv_rsp[0].gnt} !== 2'b00) begin errors++;
      $display("FAIL full_again got req=%b gnt=%b exp req=0 gnt=00", mgr_req.req, {slv_rsp[1].gnt, slv_rsp[0].gnt}); end
  endtask

  task automatic test_rready();
    // FIFO now holds indices 0,0,0,1
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 1, 10 + c);
      slv_req[0].rready = (c >= 2);
      #1;
      checks++; if (mgr_req.rready !== (c >= 2)) begin errors++;
        $display("FAIL rdy_mgr c=%0d got %b exp %b", c, mgr_req.rready, c >= 2); end
      checks++; if ({slv_rsp[1].rvalid, slv_rsp[0].rvalid} !== ((c == 5) ? 2'b10 : 2'b01)) begin errors++;
        $display("FAIL rdy_head c=%0d got %b exp %b", c, {slv_rsp[1].rvalid, slv_rsp[0].rvalid}, (c == 5) ? 2'b10 : 2'b01); end
    end
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rdy_drained got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive(0, 1, 0, 40, 1, 0, 0);
    @(negedge clk); drive(1, 0, 41, 0, 1, 0, 0);
    @(negedge clk); drive(1, 1, 42, 42, 1, 0, 0); #1;
    checks++; if ({slv_rsp[1].gnt, slv_rsp[0].gnt} !== 2'b10) begin errors++;
      $display("FAIL mid_pre got %b exp 10", {slv_rsp[1].gnt, slv_rsp[0].gnt}); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (mgr_req !== '0 || busy !== 1'b0) begin errors++;
      $display("FAIL mid_rst_mgr got req=%h busy=%b exp 0", mgr_req, busy); end
    checks++; if (slv_rsp[0] !== '0 || slv_rsp[1] !== '0) begin errors++;
      $display("FAIL mid_rst_slv got %h %h exp 0", slv_rsp[0], slv_rsp[1]); end
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (busy !== 1'b0 || mgr_req.rready !== 1'b1) begin errors++;
      $display("FAIL mid_empty got busy=%b rready=%b exp busy=0 rready=1", busy, mgr_req.rready); end
    @(negedge clk); drive(1, 1, 43, 43, 1, 0, 0); #1;
    checks++; if ({slv_rsp[1].gnt, slv_rsp[0].gnt} !== 2'b01) begin errors++;
      $display("FAIL mid_rr0 got %b exp 01", {slv_rsp[1].gnt, slv_rsp[0].gnt}); end
    @(negedge clk); drive(0, 0, 0, 0, 0, 1, 5); #1;
    checks++; if ({slv_rsp[1].rvalid, slv_rsp[0].rvalid} !== 2'b01 || busy !== 1'b1) begin errors++;
      $display("FAIL mid_resp got rvalid=%b busy=%b exp 01 busy=1", {slv_rsp[1].rvalid, slv_rsp[0].rvalid}, busy); end
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_drained got %b exp 0", busy); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_rready();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
